pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Consumer end of the next-PC path in the xgriscv core. Owns the architectural PC register and accepts the next PC produced by the next-PC calculator once the current instruction retires.
- Fetches each instruction from instruction memory over a variable-latency req/ack handshake and holds it stable, with its PC, for decode/execute.
- Detects misaligned next-PC values and unresponsive memory, and raises a sticky fetch fault for either.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
- MAX_WAIT, 255, REQ cycles without imem_ack before timeout fault; legal range 1..255.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- npc  in  32  next PC from the next-PC calculator.
- npc_valid  in  1  current instruction retires this cycle; npc is valid.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals the PC register.
- imem_ack  in  1  memory response strobe; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  instruction presented to decode.
- instr_pc  out  32  PC of instr, supplied to the next-PC calculator and the writeback PC path.
- instr_valid  out  1  instr and instr_pc are valid.
- fetch_fault  out  1  sticky fault flag.
- fault_pc  out  32  offending address: misaligned npc, or PC that timed out.

Behaviour:
- States are RST, REQ, VALID and FAULT. The state register, PC, instr, wait counter and fault registers update only on the rising edge of clk.
- While rst=1, the following values are loaded:
  - state=RST
  - pc=RESET_PC
  - instr=32'h0
  - wait counter=0
  - fetch_fault=0
  - fault_pc=0
- Rst mid-fetch abandons the outstanding request. A late imem_ack arriving in RST is ignored.
- RST:
  - imem_req=0, instr_valid=0.
  - Next state is always REQ.
  - The first imem_req is asserted one cycle after rst deasserts.
- REQ:
  - imem_req=1 and imem_addr=pc, both held stable until ack.
  - On imem_ack: instr<=imem_rdata, instr_pc<=pc, counter<=0, go to VALID.
  - Without ack: counter increments. When the counter equals MAX_WAIT-1 and no ack arrives, go to FAULT with fault_pc<=pc.
  - An ack in the same cycle as the limit wins; no fault is raised.
- VALID:
  - instr_valid=1, imem_req=0. instr and instr_pc are held until retire.
  - On npc_valid with npc[1:0]==2'b00: pc<=npc, go to REQ.
  - On npc_valid with npc[1:0]!=2'b00: fault_pc<=npc, go to FAULT. The PC is not updated.
- FAULT:
  - fetch_fault=1, imem_req=0, instr_valid=0.
  - Left only by rst.
- imem_ack outside REQ and npc_valid outside VALID are ignored.
- Latency: ack in cycle n gives instr_valid in cycle n+1. npc_valid in cycle m gives imem_req with the new address in cycle m+1.
- Peak throughput is one instruction per 2 cycles.
- PC arithmetic is not performed here. npc is taken verbatim; wrap-around (e.g. 32'hFFFF_FFFC+4) is the calculator's concern and is accepted if aligned.
- imem_addr and instr_pc are driven from registers, so there is no combinational path from npc to imem_addr.

Decomposition:
- Add to the shared xgriscv_defines.v:
  - state encodings IF_RST, IF_REQ, IF_VALID, IF_FAULT (2 bits)
  - the default RESET_PC value
- One sub-module: fetch_wait_counter (parameterised CNT_W/MAX_WAIT; inputs clear and inc; output limit). The FSM, PC and data registers stay in the top module.

Test Plan:
1. Reset release, RESET_PC=0: imem_req=1 with imem_addr=0 one cycle after rst falls; ack with rdata=32'h00500093 -> next cycle instr_valid=1, instr=32'h00500093, instr_pc=0.
2. Retire with npc=32'h4 in VALID -> next cycle imem_req=1, imem_addr=4; ack delayed 5 cycles -> addr stays 4 throughout, instr_valid=0 until the cycle after ack.
3. Retire with npc=32'h0000_0102 -> fetch_fault=1, fault_pc=32'h102, imem_req=0, instr_valid=0; further npc_valid and imem_ack have no effect until rst.
4. MAX_WAIT=4, no ack at addr 32'h10 -> FAULT entered after 4 REQ cycles, fault_pc=32'h10; second run with ack on the 4th cycle -> no fault.
5. rst asserted in REQ with ack arriving on the same edge -> instr stays 0, pc=RESET_PC, refetch from RESET_PC after release.
6. Stray imem_ack in VALID and npc_valid in REQ -> instr, instr_pc and imem_addr unchanged.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage definitions for the xgriscv core: fetch FSM state
// encodings, the default reset PC and a small PC helper.
package pc_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_RST   = 2'd0,
        IF_REQ   = 2'd1,
        IF_VALID = 2'd2,
        IF_FAULT = 2'd3
    } if_state_t;

    // Only the low two address bits decide word alignment.
    function automatic logic pc_aligned(input logic [1:0] pc_lo);
        return (pc_lo == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// Counts REQ cycles spent waiting for imem_ack; limit flags the last cycle
// before a fetch is declared unresponsive.
module fetch_wait_counter #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic limit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign limit = (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC owner and instruction fetch stage: issues one req/ack
// fetch per retired instruction and raises a sticky fault on bad npc or timeout.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        npc_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    if_state_t   state;
    if_state_t   state_nxt;

    logic [31:0] pc;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic [31:0] fault_pc_q;
    logic [31:0] fault_pc_nxt;

    logic        load_instr;
    logic        load_pc;
    logic        load_fault;
    logic        wait_clear;
    logic        wait_inc;
    logic        wait_limit;

    fetch_wait_counter #(
        .CNT_W    (CNT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (wait_clear),
        .inc   (wait_inc),
        .limit (wait_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IF_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        fetch_fault  = 1'b0;
        load_instr   = 1'b0;
        load_pc      = 1'b0;
        load_fault   = 1'b0;
        fault_pc_nxt = pc;
        wait_clear   = 1'b0;
        wait_inc     = 1'b0;

        case (state)
            IF_RST: begin
                wait_clear = 1'b1;
                state_nxt  = IF_REQ;
            end
            IF_REQ: begin
                imem_req = 1'b1;
                // An ack on the final allowed cycle still completes the fetch.
                if (imem_ack) begin
                    load_instr = 1'b1;
                    wait_clear = 1'b1;
                    state_nxt  = IF_VALID;
                end else if (wait_limit) begin
                    load_fault   = 1'b1;
                    fault_pc_nxt = pc;
                    wait_clear   = 1'b1;
                    state_nxt    = IF_FAULT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            IF_VALID: begin
                instr_valid = 1'b1;
                if (npc_valid) begin
                    if (pc_aligned(npc[1:0])) begin
                        load_pc   = 1'b1;
                        state_nxt = IF_REQ;
                    end else begin
                        load_fault   = 1'b1;
                        fault_pc_nxt = npc;
                        state_nxt    = IF_FAULT;
                    end
                end
            end
            IF_FAULT: begin
                fetch_fault = 1'b1;
            end
            default: begin
                state_nxt = IF_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            fault_pc_q <= '0;
        end else begin
            if (load_pc) begin
                pc <= npc;
            end
            if (load_instr) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= pc;
            end
            if (load_fault) begin
                fault_pc_q <= fault_pc_nxt;
            end
        end
    end

    assign imem_addr = pc;
    assign instr     = instr_q;
    assign instr_pc  = instr_pc_q;
    assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized
// traffic compared every cycle against a behavioural fetch model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          MW  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc;
    logic        npc_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int n_cmp = 0;
    int n_bad = 0;

    pc_fetch_unit #(
        .RESET_PC (RPC),
        .MAX_WAIT (MW),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .npc_valid   (npc_valid),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault),
        .fault_pc    (fault_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the fetch stage is doing, in plain terms.
    bit          m_known = 1'b0;
    bit          m_boot, m_fetch, m_hold, m_fault;
    int          m_waits;
    logic [31:0] m_pc, m_instr, m_ipc, m_fpc;

    always @(posedge clk) begin
        if (rst) begin
            m_known <= 1'b1;
            m_boot  <= 1'b1;
            m_fetch <= 1'b0;
            m_hold  <= 1'b0;
            m_fault <= 1'b0;
            m_waits <= 0;
            m_pc    <= RPC;
            m_instr <= '0;
            m_fpc   <= '0;
        end else if (m_known && !m_fault) begin
            if (m_boot) begin
                m_boot  <= 1'b0;
                m_fetch <= 1'b1;
                m_waits <= 0;
            end else if (m_fetch) begin
                if (imem_ack) begin
                    m_instr <= imem_rdata;
                    m_ipc   <= m_pc;
                    m_fetch <= 1'b0;
                    m_hold  <= 1'b1;
                end else if (m_waits + 1 == MW) begin
                    m_fetch <= 1'b0;
                    m_fault <= 1'b1;
                    m_fpc   <= m_pc;
                end else begin
                    m_waits <= m_waits + 1;
                end
            end else if (m_hold && npc_valid) begin
                m_hold <= 1'b0;
                if (npc % 4 == 0) begin
                    m_pc    <= npc;
                    m_fetch <= 1'b1;
                    m_waits <= 0;
                end else begin
                    m_fault <= 1'b1;
                    m_fpc   <= npc;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("imem_req",    {31'b0, imem_req},    {31'b0, m_fetch});
            chk("imem_addr",   imem_addr,            m_pc);
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_hold});
            chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
            chk("fault_pc",    fault_pc,             m_fpc);
            chk("instr",       instr,                m_instr);
            if (m_hold) chk("instr_pc", instr_pc, m_ipc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r, r2;
        rst = 1'b1; npc = '0; npc_valid = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        step(); step();
        chk("rst_req",   {31'b0, imem_req},    32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
        chk("rst_instr", instr,                32'h0);
        chk("rst_addr",  imem_addr,            32'h0);
        chk("mdl_rst_pc", m_pc,                32'h0);

        // reset release and first fetch
        rst = 1'b0; step();
        chk("t1_req",  {31'b0, imem_req}, 32'h1);
        chk("t1_addr", imem_addr,         32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093; step(); imem_ack = 1'b0;
        chk("t1_valid", {31'b0, instr_valid}, 32'h1);
        chk("t1_instr", instr,                32'h0050_0093);
        chk("t1_ipc",   instr_pc,             32'h0);
        chk("mdl_t1_instr", m_instr,          32'h0050_0093);

        // retire to 4, ack held off for 5 cycles
        npc_valid = 1'b1; npc = 32'h4; step(); npc_valid = 1'b0;
        chk("t2_req",  {31'b0, imem_req}, 32'h1);
        chk("t2_addr", imem_addr,         32'h4);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_wait_addr",  imem_addr,            32'h4);
            chk("t2_wait_valid", {31'b0, instr_valid}, 32'h0);
        end
        imem_ack = 1'b1; imem_rdata = 32'h00a0_0113; step(); imem_ack = 1'b0;
        chk("t2_instr", instr,    32'h00a0_0113);
        chk("t2_ipc",   instr_pc, 32'h4);

        // stray ack in VALID, stray npc_valid in REQ
        imem_ack = 1'b1; imem_rdata = 32'hdead_beef; step(); imem_ack = 1'b0;
        chk("t6_instr", instr,     32'h00a0_0113);
        chk("t6_ipc",   instr_pc,  32'h4);
        chk("t6_addr",  imem_addr, 32'h4);
        npc_valid = 1'b1; npc = 32'h8; step();
        chk("t6_addr8", imem_addr, 32'h8);
        npc = 32'h40; step(); npc_valid = 1'b0;
        chk("t6_addr_hold", imem_addr,         32'h8);
        chk("t6_req_hold",  {31'b0, imem_req}, 32'h1);
        imem_ack = 1'b1; imem_rdata = 32'h0020_8133; step(); imem_ack = 1'b0;
        chk("t6_ipc8", instr_pc, 32'h8);

        // timeout at 0x10 after MW request cycles
        npc_valid = 1'b1; npc = 32'h10; step(); npc_valid = 1'b0;
        for (int i = 0; i < MW - 1; i++) step();
        chk("t4_last_req",   {31'b0, imem_req},    32'h1);
        chk("t4_last_fault", {31'b0, fetch_fault}, 32'h0);
        step();
        chk("t4_fault",    {31'b0, fetch_fault}, 32'h1);
        chk("t4_fault_pc", fault_pc,             32'h10);
        chk("t4_req",      {31'b0, imem_req},    32'h0);
        chk("mdl_t4_fault", {31'b0, m_fault},    32'h1);

        // same address, ack on the last allowed cycle
        rst = 1'b1; step(); rst = 1'b0; step();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013; step(); imem_ack = 1'b0;
        npc_valid = 1'b1; npc = 32'h10; step(); npc_valid = 1'b0;
        for (int i = 0; i < MW - 1; i++) step();
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111; step(); imem_ack = 1'b0;
        chk("t4b_fault", {31'b0, fetch_fault}, 32'h0);
        chk("t4b_valid", {31'b0, instr_valid}, 32'h1);
        chk("t4b_instr", instr,                32'h1111_1111);
        chk("t4b_ipc",   instr_pc,             32'h10);

        // misaligned npc, fault is sticky
        npc_valid = 1'b1; npc = 32'h0000_0102; step();
        npc = 32'h8; imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_fault",    {31'b0, fetch_fault}, 32'h1);
            chk("t3_fault_pc", fault_pc,             32'h102);
            chk("t3_req",      {31'b0, imem_req},    32'h0);
            chk("t3_valid",    {31'b0, instr_valid}, 32'h0);
            chk("t3_addr",     imem_addr,            32'h10);
            step();
        end
        npc_valid = 1'b0; imem_ack = 1'b0;

        // reset during REQ with a colliding ack
        rst = 1'b1; step(); rst = 1'b0; step();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0093; step(); imem_ack = 1'b0;
        npc_valid = 1'b1; npc = 32'h20; step(); npc_valid = 1'b0;
        chk("t5_addr20", imem_addr, 32'h20);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678; step();
        chk("t5_instr", instr,             32'h0);
        chk("t5_addr",  imem_addr,         RPC);
        chk("t5_req",   {31'b0, imem_req}, 32'h0);
        step();
        chk("t5_late_ack", instr, 32'h0);
        rst = 1'b0; imem_ack = 1'b0; step();
        chk("t5_refetch_req",  {31'b0, imem_req}, 32'h1);
        chk("t5_refetch_addr", imem_addr,         RPC);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            r  = $urandom;
            r2 = $urandom;
            rst        = (r[7:0] < 8'd3) || (fetch_fault && r[9:8] == 2'b00);
            imem_ack   = (r[12:10] < 3'd3);
            imem_rdata = $urandom;
            npc_valid  = (r[15:14] == 2'b00);
            npc        = (r[19:16] == 4'h0) ? r2 : {r2[31:2], 2'b00};
            step();
        end

        rst = 1'b0; npc_valid = 1'b0; imem_ack = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
